// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// default sizing constants.
package dmem_pkg;

    localparam int unsigned DATA_WIDTH_DEF    = 32;
    localparam int unsigned ADDRESS_WIDTH_DEF = 16;
    localparam int unsigned MEM_DEPTH_DEF     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin decision: a lone request wins outright, a tie goes to
// the requester that was not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant_c,
    output logic       idx_c
);

    always_comb begin
        grant_c = 2'b00;
        idx_c   = 1'b0;
        case (req)
            2'b01: begin
                grant_c = 2'b01;
                idx_c   = 1'b0;
            end
            2'b10: begin
                grant_c = 2'b10;
                idx_c   = 1'b1;
            end
            2'b11: begin
                idx_c   = ~last;
                grant_c = last ? 2'b01 : 2'b10;
            end
            default: begin
                grant_c = 2'b00;
                idx_c   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a single-port data memory between the CPU (requester 0) and the
// DMA/debug port (requester 1); one access per three-cycle IDLE/ACCESS/RESP pass.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int unsigned MEM_DEPTH     = MEM_DEPTH_DEF
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [1:0]               Req,
    input  logic [1:0]               Write,
    input  logic [ADDRESS_WIDTH-1:0] Addr0,
    input  logic [ADDRESS_WIDTH-1:0] Addr1,
    input  logic [DATA_WIDTH-1:0]    WData0,
    input  logic [DATA_WIDTH-1:0]    WData1,
    output logic [1:0]               Ack,
    output logic                     Err,
    output logic [DATA_WIDTH-1:0]    RData,
    output logic [ADDRESS_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0]    MemWriteData,
    output logic                     MemWrite,
    input  logic [DATA_WIDTH-1:0]    MemData
);

    state_e                   state_q, state_d;
    logic [1:0]               owner_q, owner_d;
    logic                     write_q, write_d;
    logic                     in_range_q, in_range_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     last_q, last_d;
    logic [1:0]               ack_q, ack_d;
    logic                     err_q, err_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     mem_we_q, mem_we_d;

    logic [1:0]               grant_c;
    logic                     idx_c;
    logic [ADDRESS_WIDTH-1:0] sel_addr_c;
    logic [DATA_WIDTH-1:0]    sel_wdata_c;
    logic                     sel_in_range_c;

    rr_arb2 u_rr_arb2 (
        .req     (Req),
        .last    (last_q),
        .grant_c (grant_c),
        .idx_c   (idx_c)
    );

    // Winner's request fields, only meaningful while some Req bit is high
    always_comb begin
        sel_addr_c     = idx_c ? Addr1 : Addr0;
        sel_wdata_c    = idx_c ? WData1 : WData0;
        sel_in_range_c = (sel_addr_c < ADDRESS_WIDTH'(MEM_DEPTH));
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            write_q    <= 1'b0;
            in_range_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_q     <= 1'b1;
            ack_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            write_q    <= write_d;
            in_range_q <= in_range_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            last_q     <= last_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            mem_we_q   <= mem_we_d;
        end
    end

    // Ack/Err/MemWrite are computed one state early so they are flop outputs
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        write_d    = write_q;
        in_range_d = in_range_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        last_d     = last_q;
        rdata_d    = rdata_q;
        ack_d      = 2'b00;
        err_d      = 1'b0;
        mem_we_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (|Req) begin
                    state_d    = ACCESS;
                    owner_d    = grant_c;
                    write_d    = Write[idx_c];
                    addr_d     = sel_addr_c;
                    wdata_d    = sel_wdata_c;
                    in_range_d = sel_in_range_c;
                    mem_we_d   = Write[idx_c] & sel_in_range_c;
                end
            end
            ACCESS: begin
                state_d = RESP;
                rdata_d = (!write_q && in_range_q) ? MemData : '0;
                ack_d   = owner_q;
                err_d   = ~in_range_q;
            end
            RESP: begin
                state_d = IDLE;
                last_d  = owner_q[1];
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Ack          = ack_q;
    assign Err          = err_q;
    assign RData        = rdata_q;
    assign MemAddress   = addr_q;
    assign MemWriteData = wdata_q;
    assign MemWrite     = mem_we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized plus directed bench for dmem_arbiter against a transaction-level
// timeline model with a shadow memory.
module tb_dmem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 32;
    localparam int IW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req, wr;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [1:0]    ack;
    logic          err;
    logic [DW-1:0] rdata, mem_wdata, mem_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;

    logic [DW-1:0] mem [DEPTH];
    logic          bd_we;
    logic [IW-1:0] bd_idx;
    logic [DW-1:0] bd_data;

    int total = 0;
    int bad   = 0;

    // Timeline model state
    logic [DW-1:0] sh [DEPTH];
    int            cnt;
    logic          last, own, e_wr, e_in, pw_en;
    logic [AW-1:0] e_addr;
    logic [IW-1:0] pw_idx;
    logic [DW-1:0] pw_data, e_rd;
    int            we_cnt;
    int            cyc;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .Clk          (clk),
        .Rst_n        (rst_n),
        .Req          (req),
        .Write        (wr),
        .Addr0        (a0),
        .Addr1        (a1),
        .WData0       (d0),
        .WData1       (d1),
        .Ack          (ack),
        .Err          (err),
        .RData        (rdata),
        .MemAddress   (mem_addr),
        .MemWriteData (mem_wdata),
        .MemWrite     (mem_we),
        .MemData      (mem_data)
    );

    assign mem_data = (mem_addr < AW'(DEPTH)) ? mem[mem_addr[IW-1:0]] : '0;

    always @(posedge clk) begin
        if (bd_we)
            mem[bd_idx] <= bd_data;
        else if (mem_we && mem_addr < AW'(DEPTH))
            mem[mem_addr[IW-1:0]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: model advances at the posedge, DUT is checked at the negedge
    task automatic step();
        logic [1:0] exp_ack;
        @(posedge clk);
        if (cnt > 0) begin
            cnt--;
            if (cnt == 1 && pw_en) sh[pw_idx] = pw_data;
        end else if (req != 2'b00) begin
            own     = (req == 2'b11) ? ~last : req[1];
            last    = own;
            e_addr  = own ? a1 : a0;
            e_wr    = wr[own];
            e_in    = (e_addr < AW'(DEPTH));
            pw_en   = e_wr && e_in;
            pw_idx  = e_addr[IW-1:0];
            pw_data = own ? d1 : d0;
            e_rd    = (!e_wr && e_in) ? sh[pw_idx] : '0;
            cnt     = 2;
        end
        @(negedge clk);
        exp_ack = (cnt == 1) ? (own ? 2'b10 : 2'b01) : 2'b00;
        chk("ack", 64'(ack), 64'(exp_ack));
        chk("err", 64'(err), 64'(cnt == 1 && !e_in));
        chk("memwrite", 64'(mem_we), 64'(cnt == 2 && pw_en));
        if (cnt == 1) chk("rdata", 64'(rdata), 64'(e_rd));
        if (cnt == 2) chk("memaddr", 64'(mem_addr), 64'(e_addr));
        if (mem_we) we_cnt++;
        cyc++;
    endtask

    task automatic model_reset();
        cnt   = 0;
        last  = 1'b1;
        pw_en = 1'b0;
        e_in  = 1'b1;
    endtask

    // Called at a negedge; returns at a negedge with Rst_n high again
    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        model_reset();
        #1;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_memwrite", 64'(mem_we), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_memaddr", 64'(mem_addr), 64'd0);
        chk("rst_memwdata", 64'(mem_wdata), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input int i, output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!ack[i] && lat < 12);
        if (!ack[i]) chk("ack_timeout", 64'd0, 64'd1);
    endtask

    int           lat;
    logic [DW-1:0] old3;
    logic [1:0]   ack_seq [$];
    int           ack_cyc [$];

    initial begin
        rst_n = 1'b0; req = '0; wr = '0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        bd_we = 1'b0; bd_idx = '0; bd_data = '0;
        we_cnt = 0; cyc = 0;
        model_reset();

        // Preload memory while held in reset
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            bd_we   = 1'b1;
            bd_idx  = IW'(k);
            bd_data = (k == 5) ? 32'hDEADBEEF : DW'($urandom);
            sh[k]   = bd_data;
        end
        @(negedge clk);
        bd_we = 1'b0;
        do_reset();

        // Load of word 5 by the CPU
        a0 = 16'd5; wr = 2'b00; req = 2'b01;
        wait_ack(0, lat);
        chk("load5_latency", 64'(lat), 64'd2);
        chk("load5_rdata", 64'(rdata), 64'hDEADBEEF);
        req[0] = 1'b0;
        step();

        // DMA store to 7 then CPU load of 7
        we_cnt = 0;
        a1 = 16'd7; d1 = 32'h12345678; wr = 2'b10; req = 2'b10;
        wait_ack(1, lat);
        req[1] = 1'b0;
        step();
        chk("store7_we_pulses", 64'(we_cnt), 64'd1);
        a0 = 16'd7; wr = 2'b00; req = 2'b01;
        wait_ack(0, lat);
        chk("load7_rdata", 64'(rdata), 64'h12345678);
        req[0] = 1'b0;
        step();

        // Both requesting continuously after reset
        do_reset();
        a0 = 16'd1; a1 = 16'd2; wr = 2'b00; req = 2'b11;
        for (int k = 0; k < 12; k++) begin
            step();
            if (ack != 2'b00) begin
                ack_seq.push_back(ack);
                ack_cyc.push_back(cyc);
            end
        end
        req = 2'b00;
        step();
        chk("rr_ack_count", 64'(ack_seq.size()), 64'd4);
        if (ack_seq.size() == 4) begin
            chk("rr_order0", 64'(ack_seq[0]), 64'b01);
            chk("rr_order1", 64'(ack_seq[1]), 64'b10);
            chk("rr_order2", 64'(ack_seq[2]), 64'b01);
            chk("rr_order3", 64'(ack_seq[3]), 64'b10);
            for (int k = 1; k < 4; k++)
                chk("rr_spacing", 64'(ack_cyc[k] - ack_cyc[k-1]), 64'd3);
        end

        // Out-of-range store
        we_cnt = 0;
        a0 = AW'(DEPTH); d0 = 32'hCAFEF00D; wr = 2'b01; req = 2'b01;
        wait_ack(0, lat);
        chk("oor_err", 64'(err), 64'd1);
        chk("oor_rdata", 64'(rdata), 64'd0);
        req[0] = 1'b0;
        step();
        chk("oor_we_pulses", 64'(we_cnt), 64'd0);

        // Reset in the middle of a store to word 3
        old3 = sh[3];
        a0 = 16'd3; d0 = ~old3; wr = 2'b01; req = 2'b01;
        step();
        chk("abort_in_access", 64'(mem_we), 64'd1);
        do_reset();
        for (int k = 0; k < 4; k++) step();
        chk("abort_word3", 64'(mem[3]), 64'(old3));
        a0 = 16'd3; wr = 2'b00; req = 2'b01;
        wait_ack(0, lat);
        chk("abort_idle_latency", 64'(lat), 64'd2);
        req[0] = 1'b0;
        step();

        // Randomized traffic from both requesters
        for (int n = 0; n < 2000; n++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    wr[i] = 1'($urandom_range(0, 1));
                    if (i == 0) begin
                        a0 = AW'($urandom_range(0, DEPTH + 7));
                        d0 = DW'($urandom);
                    end else begin
                        a1 = AW'($urandom_range(0, DEPTH + 7));
                        d1 = DW'($urandom);
                    end
                    req[i] = 1'b1;
                end
            end
        end
        req = 2'b00;
        for (int k = 0; k < 4; k++) step();

        for (int k = 0; k < DEPTH; k++)
            chk("final_mem", 64'(mem[k]), 64'(sh[k]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
